if_stage: RTL

//   Instruction-fetch stage of the 16-bit CPU. Owns the 4-bit PC, drives the instruction ROM address,
//   and captures the combinational ROM word plus its PC into an IF/ID register. Presents a valid/ready

---
 rtl/if_stage_pkg.sv | 21 ++
 rtl/if_pc_reg.sv | 40 ++++
 rtl/if_stage.sv | 112 +++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_stage_pkg;

    localparam int unsigned IfPcW   = 4;
    localparam int unsigned IfInstW = 16;

    // Encodings are visible on state_o, so they are pinned explicitly.
    typedef enum logic [1:0] {
        IfIdle = 2'd0,
        IfRun  = 2'd1,
        IfHalt = 2'd2
    } if_state_e;

    // Next-pc source select for the pc register.
    typedef enum logic [1:0] {
        PcHold = 2'd0,
        PcInc  = 2'd1,
        PcLoad = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register with hold / increment / load next-pc mux.
module if_pc_reg
    import if_stage_pkg::*;
#(
    parameter int unsigned     PC_W   = IfPcW,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  pc_sel_e         sel_i,
    input  logic [PC_W-1:0] target_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_q;

    // Next-pc mux; increment wraps naturally at PC_W bits.
    always_comb begin
        pc_d = pc_q;
        unique case (sel_i)
            PcHold:  pc_d = pc_q;
            PcInc:   pc_d = pc_q + PC_W'(1);
            PcLoad:  pc_d = target_i;
            default: pc_d = pc_q;
        endcase
    end

    // PC state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RST_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch FSM, pc register and IF/ID pipeline register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned     PC_W   = IfPcW,
    parameter int unsigned     INST_W = IfInstW,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              halt_i,
    output logic [PC_W-1:0]   rom_addr_o,
    input  logic [INST_W-1:0] rom_inst_i,
    output logic [INST_W-1:0] inst_o,
    output logic [PC_W-1:0]   pc_o,
    output logic              valid_o,
    input  logic              ready_i,
    input  logic              br_taken_i,
    input  logic [PC_W-1:0]   br_target_i,
    output logic [1:0]        state_o
);

    if_state_e         state_d, state_q;
    logic [INST_W-1:0] inst_d, inst_q;
    logic [PC_W-1:0]   ipc_d, ipc_q;
    logic              valid_d, valid_q;
    pc_sel_e           pc_sel;
    logic [PC_W-1:0]   pc;
    logic              consumed;

    if_pc_reg #(
        .PC_W   (PC_W),
        .RST_PC (RST_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel_i    (pc_sel),
        .target_i (br_target_i),
        .pc_o     (pc)
    );

    assign consumed = valid_q && ready_i;

    // FSM next state, pc select and IF/ID next values; branch beats stall, halt beats branch.
    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        pc_sel  = PcHold;
        unique case (state_q)
            IfIdle: begin
                if (start_i) begin
                    state_d = IfRun;
                end
            end
            IfRun: begin
                if (halt_i) begin
                    // No fetch on the halt cycle; a pending word may still drain.
                    state_d = IfHalt;
                    if (br_taken_i) begin
                        pc_sel  = PcLoad;
                        valid_d = 1'b0;
                    end else if (consumed) begin
                        valid_d = 1'b0;
                    end
                end else if (br_taken_i) begin
                    // Flush: the word from the old pc is dropped even if stalled.
                    pc_sel  = PcLoad;
                    valid_d = 1'b0;
                end else if (!valid_q || ready_i) begin
                    inst_d  = rom_inst_i;
                    ipc_d   = pc;
                    valid_d = 1'b1;
                    pc_sel  = PcInc;
                end
            end
            IfHalt: begin
                if (consumed) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IfIdle;
                valid_d = 1'b0;
            end
        endcase
    end

    // FSM state and IF/ID register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IfIdle;
            inst_q  <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

    assign rom_addr_o = pc;
    assign inst_o     = inst_q;
    assign pc_o       = ipc_q;
    assign valid_o    = valid_q;
    assign state_o    = state_q;

endmodule
